// File: rtl/alu_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, one iteration per clock.
// Define ALU_MDU_SIGNED_EN to compile in signed MULT/DIV (op[1]).
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic           is_div;
  logic           dz;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b;

  logic [WIDTH:0]   msum;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;

  // diff[WIDTH] is always 0 when the trial subtract succeeds
  logic unused_diff;
  assign unused_diff = diff[WIDTH];

`ifdef ALU_MDU_SIGNED_EN
  logic             sa;
  logic             sb;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    a_in = srca;
    b_in = srcb;
    if (op[1] && srca[WIDTH-1]) a_in = -srca;
    if (op[1] && srcb[WIDTH-1]) b_in = -srcb;
  end
`else
  logic unused_op;
  assign unused_op = op[1];
  assign a_in = srca;
  assign b_in = srcb;
`endif

  // q holds the multiplier (shifted out LSB first) or the
  // dividend (shifted out MSB first, quotient shifted in)
  always_comb begin
    msum = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
    diff = {1'b0, acc, q[WIDTH-1]} - {2'b00, b};
    if (is_div) begin
      if (!diff[WIDTH+1]) acc_n = diff[WIDTH-1:0];
      else                acc_n = {acc[WIDTH-2:0], q[WIDTH-1]};
      q_n = {q[WIDTH-2:0], ~diff[WIDTH+1]};
    end else begin
      acc_n = msum[WIDTH:1];
      q_n   = {msum[0], q[WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_n = acc_n;
    lo_n = q_n;
`ifdef ALU_MDU_SIGNED_EN
    prod = {acc_n, q_n};
    if (is_div) begin
      if (sa ^ sb) lo_n = -q_n;
      if (sa)      hi_n = -acc_n;
    end else if (sa ^ sb) begin
      prod = -prod;
      hi_n = prod[2*WIDTH-1:WIDTH];
      lo_n = prod[WIDTH-1:0];
    end
`endif
    // remainder already equals srca here, quotient is forced
    if (dz) lo_n = '1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      acc         <= '0;
      q           <= '0;
      b           <= '0;
`ifdef ALU_MDU_SIGNED_EN
      sa          <= 1'b0;
      sb          <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            is_div      <= op[0];
            dz          <= op[0] && (srcb == '0);
            acc         <= '0;
            count       <= CW'(WIDTH);
            if (op[0]) begin
              q <= a_in;
              b <= b_in;
            end else begin
              q <= b_in;
              b <= a_in;
            end
`ifdef ALU_MDU_SIGNED_EN
            sa <= op[1] && srca[WIDTH-1];
            sb <= op[1] && srcb[WIDTH-1];
`endif
          end
        end
        RUN: begin
          acc   <= acc_n;
          q     <= q_n;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            hi          <= hi_n;
            lo          <= lo_n;
            div_by_zero <= dz;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: driver pushes model results,
// a negedge monitor checks timing, handshake and HI/LO.
module tb_alu_mdu;

`ifdef ALU_MDU_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .srca(srca),
    .srcb(srcb),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc = -1000;
  logic rst_seen = 1'b0;
  logic acc_seen = 1'b0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;
  exp_t        me;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
  endtask

  // Reference: plain arithmetic on whole 64-bit products/quotients
  function automatic exp_t model(input logic [1:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    int          sa;
    int          sb;
    bit          sg;
    sa = a;
    sb = b;
    sg = SEN && o[1];
    e.dz = 1'b0;
    e.cyc = 0;
    if (!o[0]) begin
      if (sg) p = longint'(sa) * longint'(sb);
      else    p = {32'd0, a} * {32'd0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.lo = '1;
      e.hi = a;
      e.dz = 1'b1;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
        e.lo = a;
        e.hi = '0;
      end else begin
        e.lo = sa / sb;
        e.hi = sa % sb;
      end
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
    acc_seen <= rst_n && start && !busy;
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset_outputs", {busy, done, div_by_zero, hi, lo},
          {3'b000, 64'd0});
      sb_q.delete();
      exp_hi   = '0;
      exp_lo   = '0;
      exp_dz   = 1'b0;
      last_acc = -1000;
    end else begin
      if (acc_seen) begin
        last_acc = cyc;
        exp_dz   = 1'b0;
      end
      chk("busy", busy, (cyc - last_acc) < 32);
      chk("busy_done_excl", busy && done, 1'b0);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          me = sb_q.pop_front();
          chk("latency", cyc, me.cyc + 32);
          chk("hi", hi, me.hi);
          chk("lo", lo, me.lo);
          chk("div_by_zero", div_by_zero, me.dz);
          exp_hi = me.hi;
          exp_lo = me.lo;
          exp_dz = me.dz;
        end
      end else begin
        chk("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
        chk("hold_dz", div_by_zero, exp_dz);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    #1;
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    if (!busy) begin
      e = model(o, a, b);
      e.cyc = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    #1;
    start = 1'b0;
    srca  = $urandom;
    srcb  = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) return;
    end
    fail_bound("wait_idle");
  endtask

  task automatic back_to_back(input logic [1:0] o1, input logic [31:0] a1,
                              input logic [31:0] b1, input logic [1:0] o2,
                              input logic [31:0] a2, input logic [31:0] b2);
    exp_t e;
    bit   got;
    got = 1'b0;
    issue_hold(o1, a1, b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      op   = o2;
      srca = a2;
      srcb = b2;
      if (!busy) begin
        e = model(o2, a2, b2);
        e.cyc = cyc + 1;
        sb_q.push_back(e);
        got = 1'b1;
        break;
      end
    end
    @(negedge clk);
    #1;
    start = 1'b0;
    if (!got) fail_bound("back_to_back");
  endtask

  task automatic issue_hold(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    #1;
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    if (!busy) begin
      e = model(o, a, b);
      e.cyc = cyc + 1;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    issue(2'b00, 32'hffff_ffff, 32'hffff_ffff);
    wait_idle();
    issue(2'b11, 32'hffff_fff9, 32'd2);
    wait_idle();
    issue(2'b01, 32'd100, 32'd0);
    wait_idle();
    issue(2'b00, 32'd3, 32'd4);
    wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hffff_ffff);
    wait_idle();
    issue(2'b11, 32'h8000_0000, 32'hffff_ffff);
    wait_idle();
    issue(2'b11, 32'hffff_ff00, 32'd0);
    wait_idle();
    issue(2'b11, 32'd7, 32'hffff_fffe);
    wait_idle();

    issue(2'b00, 32'd1234, 32'd5678);
    repeat (3) issue(2'b01, $urandom, $urandom);
    issue(2'b10, 32'hdead_beef, 32'h1234_5678);
    wait_idle();

    back_to_back(2'b00, 32'd11, 32'd13, 2'b01, 32'd1000, 32'd7);
    wait_idle();

    issue(2'b01, 32'd123456, 32'd789);
    repeat (8) @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_done_after_reset", n, 0);
    issue(2'b00, 32'd6, 32'd7);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hffff_ffff; end
        default: ;
      endcase
      issue(ro, ra, rb);
      if ($urandom_range(0, 3) == 0) issue(2'b00, $urandom, $urandom);
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
